// File: rtl/bus_arbiter4_pkg.sv
// Shared definitions for the four-requester bus arbiter: requester count,
// index width and the FSM state encoding.
package bus_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/bus_arbiter4_rr_pick4.sv
// Combinational round-robin selector: the first requester found scanning
// upward from (last+1) mod 4 wins.
module rr_pick4
  import bus_arbiter4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
  always_comb begin
    valid  = 1'b0;
    winner = last;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      // 2-bit arithmetic wraps 3->0, and k=4 lands back on last itself.
      cand = last + IDX_W'(k);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter4.sv
// Four-way round-robin bus arbiter with tenure-limited preemption and a
// one-cycle all-zero turnaround between successive grants.
module bus_arbiter4
  import bus_arbiter4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] owner,
  output logic             busy
);

  localparam logic [7:0] MAX_T = 8'(MAX_HOLD);

  state_t           state;
  logic [7:0]       tenure;
  logic [IDX_W-1:0] last;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_winner;
  logic             others_waiting;

  rr_pick4 u_pick (
    .req    (req),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign others_waiting = |(req & ~gnt);

  // NOTE: all state and outputs are registered with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      busy   <= 1'b0;
      owner  <= '0;
      tenure <= '0;
      last   <= IDX_W'(N_REQ - 1);
    end else begin
      unique case (state)
        ST_IDLE, ST_TURN: begin
          gnt  <= '0;
          busy <= 1'b0;
          if (pick_valid) begin
            state  <= ST_GRANT;
            gnt    <= N_REQ'(1) << pick_winner;
            busy   <= 1'b1;
            owner  <= pick_winner;
            last   <= pick_winner;
            tenure <= 8'd1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          // Release or preempt; either way the bus goes idle for one turnaround cycle.
          if (!req[owner] || (tenure == MAX_T && others_waiting)) begin
            state <= ST_TURN;
            gnt   <= '0;
            busy  <= 1'b0;
          end else if (tenure < MAX_T) begin
            tenure <= tenure + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter4.sv
// Self-checking bench for bus_arbiter4: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_bus_arbiter4;

  localparam int MAX_HOLD = 8;
  localparam int STARVE   = 4 * (MAX_HOLD + 1);

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t vecs [15];

  // Behavioural model: who holds the bus (-1 = nobody), for how long, and
  // who was granted last. Idle and turnaround behave alike from outside.
  int m_owner;
  int m_tenure;
  int m_last;
  int m_shown;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs after a falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic cycle(input logic r, input logic [3:0] q);
    rst = r;
    req = q;
    @(negedge clk);
  endtask

  function automatic int rr_choose(input logic [3:0] q, input int from_last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from_last + k) % 4;
      if (q[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_tenure = 0;
    m_last   = 3;
    m_shown  = 0;
  endtask

  task automatic model_step(input logic [3:0] q);
    if (m_owner < 0) begin
      int w;
      w = rr_choose(q, m_last);
      if (w >= 0) begin
        m_owner  = w;
        m_last   = w;
        m_shown  = w;
        m_tenure = 1;
      end
    end else begin
      logic [3:0] others;
      others = q & ~(4'b0001 << m_owner);
      if (!q[m_owner] || (m_tenure == MAX_HOLD && others != 4'b0000)) m_owner = -1;
      else if (m_tenure < MAX_HOLD) m_tenure++;
    end
  endtask

  function automatic logic [3:0] model_gnt();
    return (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
  endfunction

  initial begin
    logic [3:0] cur;
    logic [3:0] prev_gnt;
    int         run;
    int         waiting [4];
    logic [3:0] exp_g;
    bit         starved;

    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[6]  = '{1'b0, 4'b1001, 4'b0000, 2'd1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1};
    vecs[8]  = '{1'b0, 4'b0010, 4'b0000, 2'd3, 1'b0};
    vecs[9]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[10] = '{1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1};
    vecs[12] = '{1'b0, 4'b0100, 4'b0000, 2'd1, 1'b0};
    vecs[13] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[14] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};

    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);

    for (int v = 0; v < 15; v++) begin
      cycle(vecs[v].rst, vecs[v].req);
      check($sformatf("vec%0d_gnt", v),   32'(gnt),   32'(vecs[v].gnt));
      check($sformatf("vec%0d_owner", v), 32'(owner), 32'(vecs[v].owner));
      check($sformatf("vec%0d_busy", v),  32'(busy),  32'(vecs[v].busy));
    end

    // All four requesting: MAX_HOLD beats each, one zero beat between owners.
    cycle(1'b1, 4'b0000);
    for (int c = 1; c <= 4 * (MAX_HOLD + 1) + 1; c++) begin
      int p;
      cycle(1'b0, 4'b1111);
      p = (c - 1) % (MAX_HOLD + 1);
      exp_g = (p == MAX_HOLD) ? 4'b0000 : (4'b0001 << (((c - 1) / (MAX_HOLD + 1)) % 4));
      check($sformatf("rot_c%0d", c), 32'(gnt), 32'(exp_g));
    end

    // A lone requester is never preempted.
    cycle(1'b1, 4'b0000);
    for (int c = 1; c <= 20; c++) begin
      cycle(1'b0, 4'b0100);
      check($sformatf("solo_c%0d", c), 32'(gnt), 32'h4);
    end
    check("solo_owner", 32'(owner), 32'd2);

    // Random traffic: sticky requests that toggle occasionally.
    cycle(1'b1, 4'b0000);
    model_reset();
    check("rand_reset_gnt", 32'(gnt), 32'(model_gnt()));
    cur      = 4'b0000;
    prev_gnt = 4'b0000;
    run      = 0;
    for (int i = 0; i < 4; i++) waiting[i] = 0;

    for (int n = 0; n < 10000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) cur[b] = ~cur[b];
      prev_gnt = gnt;
      cycle(1'b0, cur);
      model_step(cur);

      check("rand_gnt",   32'(gnt),   32'(model_gnt()));
      check("rand_busy",  32'(busy),  32'(m_owner >= 0));
      check("rand_owner", 32'(owner), 32'(m_shown));
      check("onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("adjacent", 32'(prev_gnt != 4'b0000 && gnt != 4'b0000 && gnt != prev_gnt), 32'd0);
      if (prev_gnt != 4'b0000 && run >= MAX_HOLD && (cur & ~prev_gnt) != 4'b0000)
        check("max_hold", 32'(gnt), 32'd0);
      run = (gnt != 4'b0000 && gnt == prev_gnt) ? run + 1 : ((gnt != 4'b0000) ? 1 : 0);

      starved = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (cur[i] && !gnt[i]) waiting[i]++;
        else waiting[i] = 0;
        if (waiting[i] > STARVE) starved = 1'b1;
      end
      check("starvation", 32'(starved), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter4.md
BUS_ARBITER4 -- requirements
Module: bus_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8; maximum consecutive grant cycles before preemption when another requester waits; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester bus request; bit i = requester i.
REQ-005 gnt  output 4  one-hot or zero grant; bit i drives the enable of requester i's tri-state bus driver.
REQ-006 owner  output 2  index of current grantee; valid only while busy=1.
REQ-007 busy  output 1  high while any gnt bit is high.

Function
REQ-008 All outputs SHALL be registered; gnt SHALL never have more than one bit set in any cycle.
REQ-009 FSM SHALL have states IDLE, GRANT, TURN.
REQ-010 IDLE: gnt=0; if req!=0, select winner round-robin starting at (last+1) mod 4, go to GRANT; gnt[winner] high from the next cycle (latency 1).
REQ-011 IDLE with req=0: remain IDLE, last unchanged.
REQ-012 On entering GRANT: last<=winner, owner<=winner, tenure counter<=1.
REQ-013 GRANT, req[owner]=1 and (tenure<MAX_HOLD or no other req bit set): hold gnt; tenure increments, saturating at MAX_HOLD.
REQ-014 GRANT, req[owner]=0: release; gnt<=0 next cycle, go to TURN.
REQ-015 GRANT, tenure==MAX_HOLD and any other req bit set: preempt; gnt<=0 next cycle, go to TURN, regardless of req[owner].
REQ-016 TURN: gnt=0 for exactly one cycle (bus turnaround, no two drivers ever enabled in adjacent cycles); arbitrate as in IDLE using current req; if winner exists go to GRANT, else IDLE.
REQ-017 Consequence: between two different or same owners, gnt SHALL be all-zero for exactly one cycle.
REQ-018 Round-robin pointer SHALL wrap 3->0; preempted requester still requesting SHALL be lowest priority in the next arbitration.
REQ-019 Requests dropped before being granted SHALL be ignored (no request latching).
REQ-020 busy SHALL equal |gnt each cycle; owner SHALL hold its last value while busy=0.

Reset
REQ-021 rst=1 at a clock edge SHALL force: state IDLE, gnt=4'b0000, busy=0, owner=2'd0, tenure=0, last=2'd3 (requester 0 first priority after reset).
REQ-022 Reset asserted mid-grant SHALL drop gnt to zero at that edge; no TURN cycle is inserted; arbitration resumes the first cycle after rst deasserts.

Structure
REQ-023 Shared package SHALL hold the FSM state encoding (IDLE/GRANT/TURN, 2-bit), requester count constant N_REQ=4 and index width 2.
REQ-024 Round-robin selection SHALL be one combinational sub-module rr_pick4 (inputs req[3:0], last[1:0]; outputs valid, winner[1:0]).
REQ-025 Block SHALL contain no tri-state logic itself; it only produces enables for the external tri-state bus drivers.

Verification
REQ-026 After reset, req=4'b0001 at cycle 0 -> gnt=4'b0001, owner=0, busy=1 at cycle 1.
REQ-027 req=4'b1111 held constant, MAX_HOLD=8 -> gnt sequence 0001 x8, 0000, 0010 x8, 0000, 0100 x8, 0000, 1000 x8, 0000, 0001 ...
REQ-028 Owner 2 granted, req=4'b0100 only, held 20 cycles -> gnt=0100 for all 20 cycles (no preemption without competitor).
REQ-029 Owner 1 granted, req[1] drops at cycle n -> gnt=0000 at n+1; with req=4'b1001 pending, gnt=1000 at n+2 (3 beats 0 after last=1).
REQ-030 rst asserted while gnt=0010 -> gnt=0000, busy=0 next edge; after deassert with req=4'b1010, gnt=0010 one cycle later (last reset to 3, so 1 beats 3).
REQ-031 Random req for 10k cycles -> assertions: gnt one-hot-or-zero, never two different nonzero gnt in adjacent cycles, no requester held >MAX_HOLD while another requests, every continuously requesting requester granted within 4*(MAX_HOLD+1) cycles.
